max_pool_2x2: RTL and testbench
===============================

// Module: max_pool_2x2
// PURPOSE
//   2x2 stride-2 max-pooling stage directly downstream of the ReLU core in the CNN datapath.
//   Consumes a row-major 32-bit pixel stream (Data_In/Valid_In), one feature-map channel per frame.
//   Emits one pooled value per 2x2 window with Valid_Out, plus end-of-frame markers.
//   Uses a half-row line buffer and has no backpressure, so it accepts one pixel per clock when Valid_In=1.
// PARAMETERS
//   DATA_W  32  pixel width; compared as signed two's complement
//   IMG_W   28  input frame width in pixels (>=2)
//   IMG_H   28  input frame height in pixels (>=2)
// PORTS
//   clk        in   1       single clock; all logic on rising edge
//   rst        in   1       synchronous, active-high reset
//   Data_In    in   DATA_W  input pixel (ReLU output)
//   Valid_In   in   1       Data_In valid this cycle; pixel consumed when 1
//   Data_Out   out  DATA_W  pooled maximum
//   Valid_Out  out  1       Data_Out valid; 1-cycle pulse per window
//   Out_Last   out  1       high with Valid_Out on the final window of a frame
//   Frame_Done out  1       1-cycle pulse, one clock after the last input pixel of a frame
// BEHAVIOUR
//   Reset: Data_Out=0, Valid_Out=0, Out_Last=0, Frame_Done=0; col=0, row=0, state=EVEN.
//     Line buffer is not cleared; it is always written before being read.
//   Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only when Valid_In=1.
//     col wraps to 0 and row increments at col=IMG_W-1. Both wrap to 0 at the last pixel of a frame.
//   Valid_In=0 (bubble): counters, state and registers hold. Valid_Out/Out_Last/Frame_Done drop to 0.
//   Data_Out holds its last value when Valid_Out=0. It never goes high-Z.
//   Horizontal pair, when col < 2*(IMG_W/2):
//     col even: hreg <= Data_In.
//     col odd:  m = max(hreg, Data_In), using signed compare; ties pick either operand (equal values).
//   FSM (row-parity state), updated at each row end:
//     EVEN: on col odd, linebuf[col>>1] <= m. At row end -> ODD.
//     ODD:  on col odd, Data_Out <= max(linebuf[col>>1], m) and Valid_Out=1 on the next clock.
//       Latency is 1 clock after the 4th pixel of the window.
//       At row end -> EVEN, or -> DROP if IMG_H is odd and the next row is IMG_H-1.
//     DROP: pixels are consumed with no linebuf write and no output. At frame end -> EVEN.
//   Odd IMG_W: pixel at col=IMG_W-1 is consumed and ignored (no hreg/linebuf update).
//   Out_Last is set on the window at pooled (row IMG_H/2-1, col IMG_W/2-1).
//   Frame_Done=1 one clock after the pixel at (IMG_H-1, IMG_W-1) is accepted.
//     For even IMG_W and IMG_H, it is coincident with Out_Last.
//   Outputs per frame = (IMG_W/2)*(IMG_H/2). Back-to-back frames need no gap cycle.
//   Reset mid-frame: the partial frame is discarded and counting restarts at (0,0) on the next valid pixel.
//     No window straddling the reset is ever emitted.
//   Line buffer depth: IMG_W/2 entries of DATA_W. Counter width: $clog2(IMG_W), $clog2(IMG_H).
// TESTING
//   T1 IMG_W=IMG_H=4, Data_In=0..15 contiguous -> Data_Out 5,7,13,15.
//      Valid_Out 1 clock after inputs 5,7,13,15; Out_Last and Frame_Done high with 15.
//   T2 Same data with Valid_In toggling 1,0,1,0 -> same values, each 1 clock after the window's last pixel.
//      Valid_Out low during bubbles.
//   T3 Signed compare: window {0xFFFFFFFB,0xFFFFFFFD,0xFFFFFFF8,0xFFFFFFFF} -> 0xFFFFFFFF.
//      Window {0,0x7FFFFFFF,0x80000000,1} -> 0x7FFFFFFF.
//   T4 IMG_W=IMG_H=5, Data_In=0..24 -> outputs 6,8,16,18 only, with Out_Last on 18.
//      Column 4 and row 4 produce nothing; Frame_Done 1 clock after 24.
//   T5 IMG_W=IMG_H=4: feed 0..5, assert rst 1 cycle, then feed 0..15 -> outputs exactly 5,7,13,15.
//      All outputs 0 during and after the reset cycle.
//   T6 Two 4x4 frames back-to-back (0..15, then 100..115) -> 5,7,13,15,105,107,113,115.
//      Two Out_Last pulses and two Frame_Done pulses.

Source files
------------

// File: rtl/max_pool_2x2_if.sv
// Pixel stream interface for the 2x2 max-pooling stage.
// The master drives pixels in and observes pooled results.
// The slave is the pooling stage itself.
interface max_pool_2x2_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] Data_In;
  logic              Valid_In;
  logic [DATA_W-1:0] Data_Out;
  logic              Valid_Out;
  logic              Out_Last;
  logic              Frame_Done;

  modport master (
    output Data_In, Valid_In,
    input  Data_Out, Valid_Out, Out_Last, Frame_Done
  );

  modport slave (
    input  Data_In, Valid_In,
    output Data_Out, Valid_Out, Out_Last, Frame_Done
  );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max-pooling stage for a row-major signed pixel stream.
// Even rows fold horizontal pair maxima into a half-row line buffer.
// Odd rows combine the buffered maximum with the current pair and emit one result per window.
// A trailing odd row or column is consumed without producing output.
// There is no backpressure: one pixel is accepted on every clock with Valid_In high.
module max_pool_2x2 #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic           clk,
  input  logic           rst,
  max_pool_2x2_if.slave  bus
);

  localparam int CW       = $clog2(IMG_W);
  localparam int RW       = $clog2(IMG_H);
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam bit W_ODD    = (IMG_W % 2) == 1;
  localparam bit H_ODD    = (IMG_H % 2) == 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_POOL_LAST = CW'(2 * (IMG_W / 2) - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * (IMG_H / 2) - 1);
  localparam logic [RW-1:0] ROW_PRE_DROP  = RW'(IMG_H - 2);

  // Row-parity state: EVEN rows fill the line buffer, ODD rows emit, DROP skips an unpaired last row.
  typedef enum logic [1:0] {
    ST_EVEN = 2'd0,
    ST_ODD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] hreg_q;
  logic [DATA_W-1:0] linebuf [LB_DEPTH];
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              done_q;

  logic              col_end;
  logic              frame_end;
  logic              in_pair;
  logic              pair_done;
  logic              lb_we;
  logic [LB_AW-1:0]  lb_idx;
  logic [DATA_W-1:0] hmax;
  logic [DATA_W-1:0] pool;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Position decode, pair maxima and next counter/state values for the pixel on the bus.
  always_comb begin
    col_end   = (col_q == COL_LAST);
    frame_end = col_end && (row_q == ROW_LAST);
    // The unpaired last column of an odd-width frame is consumed but never pooled.
    in_pair   = !(W_ODD && col_end);
    pair_done = bus.Valid_In && in_pair && col_q[0];
    lb_idx    = LB_AW'(col_q >> 1);
    hmax      = smax(hreg_q, bus.Data_In);
    pool      = smax(linebuf[lb_idx], hmax);
    lb_we     = pair_done && (state_q == ST_EVEN);

    col_d = col_end ? '0 : col_q + 1'b1;
    row_d = row_q;
    if (col_end) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end

    unique case (state_q)
      ST_EVEN: state_d = ST_ODD;
      ST_ODD:  state_d = (H_ODD && (row_q == ROW_PRE_DROP)) ? ST_DROP : ST_EVEN;
      default: state_d = ST_EVEN;
    endcase
  end

  // Pair holding register and line buffer; both are always written before they are read.
  // NOTE: storage that is provably written before use is left out of reset so it maps to plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (bus.Valid_In && in_pair && !col_q[0]) begin
      hreg_q <= bus.Data_In;
    end
    if (lb_we) begin
      linebuf[lb_idx] <= hmax;
    end
  end

  // Counters, row-parity FSM and registered result/marker outputs.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= ST_EVEN;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      if (bus.Valid_In) begin
        col_q  <= col_d;
        row_q  <= row_d;
        done_q <= frame_end;
        if (col_end) begin
          state_q <= state_d;
        end
        if (pair_done && (state_q == ST_ODD)) begin
          data_q  <= pool;
          valid_q <= 1'b1;
          last_q  <= (row_q == ROW_POOL_LAST) && (col_q == COL_POOL_LAST);
        end
      end
    end
  end

  assign bus.Data_Out   = data_q;
  assign bus.Valid_Out  = valid_q;
  assign bus.Out_Last   = last_q;
  assign bus.Frame_Done = done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: a 4x4 instance and a 5x5 instance share clock and reset.
// Each accepted pixel is followed by a check of all outputs one clock later.
module tb_max_pool_2x2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  max_pool_2x2_if #(.DATA_W(32)) bus4 ();
  max_pool_2x2_if #(.DATA_W(32)) bus5 ();

  max_pool_2x2 #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  max_pool_2x2 #(.DATA_W(32), .IMG_W(5), .IMG_H(5)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Expected Data_Out per instance (it holds between results); index 0 = 4x4, 1 = 5x5.
  logic [31:0] held [2];

  logic [31:0] pix_q[$];
  int          trig_q[$];
  logic [31:0] expd_q[$];
  int          elast_q[$];
  int          edone_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit big, input logic v, input logic [31:0] d);
    if (big) begin
      bus5.Valid_In = v;
      bus5.Data_In  = d;
    end else begin
      bus4.Valid_In = v;
      bus4.Data_In  = d;
    end
  endtask

  task automatic check_outs(input bit big, input string tag,
                            input logic v, input logic l, input logic d);
    logic [31:0] od;
    logic        ov, ol, odn;
    if (big) begin
      od = bus5.Data_Out; ov = bus5.Valid_Out; ol = bus5.Out_Last; odn = bus5.Frame_Done;
    end else begin
      od = bus4.Data_Out; ov = bus4.Valid_Out; ol = bus4.Out_Last; odn = bus4.Frame_Done;
    end
    check($sformatf("%s valid", tag), {31'b0, ov},  {31'b0, v});
    check($sformatf("%s last",  tag), {31'b0, ol},  {31'b0, l});
    check($sformatf("%s done",  tag), {31'b0, odn}, {31'b0, d});
    check($sformatf("%s data",  tag), od, held[big]);
  endtask

  task automatic clear_exp();
    pix_q.delete();
    trig_q.delete();
    expd_q.delete();
    elast_q.delete();
    edone_q.delete();
  endtask

  // Streams pix_q into one instance; with gaps, a bubble follows every pixel.
  task automatic run_frame(input bit big, input bit gaps, input string name);
    int   k;
    logic exp_v, exp_l, exp_d;
    k = 0;
    for (int i = 0; i < pix_q.size(); i++) begin
      drive(big, 1'b1, pix_q[i]);
      @(posedge clk); #1;
      exp_v = (k < trig_q.size()) && (trig_q[k] == i);
      exp_l = 1'b0;
      foreach (elast_q[j]) if (elast_q[j] == i) exp_l = 1'b1;
      exp_d = 1'b0;
      foreach (edone_q[j]) if (edone_q[j] == i) exp_d = 1'b1;
      if (exp_v) begin
        held[big] = expd_q[k];
        k++;
      end
      check_outs(big, $sformatf("%s px%0d", name, i), exp_v, exp_l, exp_d);
      if (gaps) begin
        drive(big, 1'b0, 32'hDEADBEEF);
        @(posedge clk); #1;
        check_outs(big, $sformatf("%s gap%0d", name, i), 1'b0, 1'b0, 1'b0);
      end
    end
    drive(big, 1'b0, 32'h0);
  endtask

  task automatic load_ramp_4x4(input logic [31:0] base);
    for (int i = 0; i < 16; i++) pix_q.push_back(base + 32'(i));
  endtask

  task automatic exp_ramp_4x4();
    trig_q  = '{5, 7, 13, 15};
    expd_q  = '{32'd5, 32'd7, 32'd13, 32'd15};
    elast_q = '{15};
    edone_q = '{15};
  endtask

  initial begin
    held[0] = 32'h0;
    held[1] = 32'h0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_outs(1'b0, "reset4", 1'b0, 1'b0, 1'b0);
    check_outs(1'b1, "reset5", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // T1: contiguous 0..15 on the 4x4 instance.
    clear_exp();
    load_ramp_4x4(32'd0);
    exp_ramp_4x4();
    run_frame(1'b0, 1'b0, "T1");

    // T2: same frame with a bubble after every pixel.
    clear_exp();
    load_ramp_4x4(32'd0);
    exp_ramp_4x4();
    run_frame(1'b0, 1'b1, "T2");

    // T3: signed comparisons, including extremes and ties.
    clear_exp();
    pix_q = '{32'hFFFFFFFB, 32'hFFFFFFFD, 32'h00000000, 32'h7FFFFFFF,
              32'hFFFFFFF8, 32'hFFFFFFFF, 32'h80000000, 32'h00000001,
              32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFE,
              32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFE};
    trig_q  = '{5, 7, 13, 15};
    expd_q  = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005, 32'hFFFFFFFE};
    elast_q = '{15};
    edone_q = '{15};
    run_frame(1'b0, 1'b0, "T3");

    // T4: odd 5x5 frame; last row and column are dropped.
    clear_exp();
    for (int i = 0; i < 25; i++) pix_q.push_back(32'(i));
    trig_q  = '{6, 8, 16, 18};
    expd_q  = '{32'd6, 32'd8, 32'd16, 32'd18};
    elast_q = '{18};
    edone_q = '{24};
    run_frame(1'b1, 1'b0, "T4");

    // T5: partial frame, one reset cycle, then a full frame.
    clear_exp();
    for (int i = 0; i < 6; i++) pix_q.push_back(32'(i));
    trig_q = '{5};
    expd_q = '{32'd5};
    run_frame(1'b0, 1'b0, "T5pre");
    rst = 1'b1;
    @(posedge clk); #1;
    held[0] = 32'h0;
    held[1] = 32'h0;
    check_outs(1'b0, "T5rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_outs(1'b0, "T5idle", 1'b0, 1'b0, 1'b0);
    clear_exp();
    load_ramp_4x4(32'd0);
    exp_ramp_4x4();
    run_frame(1'b0, 1'b0, "T5");

    // T6: two frames back-to-back with no gap.
    clear_exp();
    load_ramp_4x4(32'd0);
    load_ramp_4x4(32'd100);
    trig_q  = '{5, 7, 13, 15, 21, 23, 29, 31};
    expd_q  = '{32'd5, 32'd7, 32'd13, 32'd15, 32'd105, 32'd107, 32'd113, 32'd115};
    elast_q = '{15, 31};
    edone_q = '{15, 31};
    run_frame(1'b0, 1'b0, "T6");
    @(posedge clk); #1;
    check_outs(1'b0, "T6tail", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
